// File: rtl/ad4008_pkg.sv
// Shared AD4008 sequencing types and default timing.
// Imported by the conversion controller and the capture side.
package ad4008_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_QUIET  = 3'd2,
    ST_SCK_HI = 3'd3,
    ST_SCK_LO = 3'd4,
    ST_DONE   = 3'd5
  } ad4008_state_e;

  localparam int AD4008_CLK_DIV      = 2;
  localparam int AD4008_CONV_CYCLES  = 20;
  localparam int AD4008_QUIET_CYCLES = 2;
  localparam int AD4008_NUM_BITS     = 16;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ad4008_cnv_ctrl_period_timer.sv
// Free-running auto-trigger timer for the AD4008 sequencer.
// Ticks once every i_period cycles; period 0 parks it.
module ad4008_period_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_period,
  output logic        o_tick
);

  logic [15:0] r_cnt;
  logic        w_en;

  assign w_en   = (i_period != 16'd0);
  // >= so a period lowered under the count fires at once
  assign o_tick = w_en && (r_cnt >= (i_period - 16'd1));

  // count up, reload on tick, hold at zero when disabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= 16'd0;
    else if (!w_en || o_tick)
      r_cnt <= 16'd0;
    else
      r_cnt <= r_cnt + 16'd1;
  end

endmodule

// File: rtl/ad4008_cnv_ctrl.sv
// AD4008 conversion sequencer: CNV pulse, burst SCK,
// data_ready strobe, overrun detect and sample counter.
module ad4008_cnv_ctrl
  import ad4008_pkg::*;
#(
  parameter int CLK_DIV      = AD4008_CLK_DIV,
  parameter int CONV_CYCLES  = AD4008_CONV_CYCLES,
  parameter int QUIET_CYCLES = AD4008_QUIET_CYCLES,
  parameter int NUM_BITS     = AD4008_NUM_BITS
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] period,
  output logic        cnv,
  output logic        sck,
  output logic        busy,
  output logic        data_ready,
  output logic        overrun,
  output logic [15:0] sample_count
);

  localparam int TMAX = max3(CLK_DIV, CONV_CYCLES, QUIET_CYCLES);
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int BW   = $clog2(NUM_BITS) + 1;

  localparam logic [TW-1:0] CONV_LAST  = TW'(CONV_CYCLES - 1);
  localparam logic [TW-1:0] QUIET_LAST = TW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_LAST  = BW'(NUM_BITS - 1);

  ad4008_state_e r_state, w_state_nxt;
  logic [TW-1:0] r_tmr, w_tmr_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic          r_cnv, w_cnv_nxt;
  logic          r_sck, w_sck_nxt;
  logic          r_busy;
  logic          r_dr, w_dr_nxt;
  logic          r_ovr, w_ovr_nxt;
  logic [15:0]   r_sample_cnt, w_cnt_nxt;
  logic          w_tick;
  logic          w_trig;

  ad4008_period_timer u_timer (
    .i_clk    (sysclk),
    .i_rst_n  (reset),
    .i_period (period),
    .o_tick   (w_tick)
  );

  assign w_trig = start | w_tick;

  // next state and next registered outputs
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_bit_nxt   = r_bit;
    w_cnv_nxt   = r_cnv;
    w_sck_nxt   = r_sck;
    w_dr_nxt    = 1'b0;
    w_ovr_nxt   = w_trig && (r_state != ST_IDLE);
    w_cnt_nxt   = r_sample_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_state_nxt = ST_CONV;
          w_cnv_nxt   = 1'b1;
          w_tmr_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      ST_CONV: begin
        if (r_tmr == CONV_LAST) begin
          w_state_nxt = ST_QUIET;
          w_cnv_nxt   = 1'b0;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      ST_QUIET: begin
        if (r_tmr == QUIET_LAST) begin
          w_state_nxt = ST_SCK_HI;
          w_sck_nxt   = 1'b1;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      ST_SCK_HI: begin
        if (r_tmr == DIV_LAST) begin
          w_state_nxt = ST_SCK_LO;
          w_sck_nxt   = 1'b0;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      ST_SCK_LO: begin
        if (r_tmr == DIV_LAST) begin
          w_tmr_nxt = '0;
          w_bit_nxt = r_bit + 1'b1;
          if (r_bit == BITS_LAST) begin
            w_state_nxt = ST_DONE;
            w_dr_nxt    = 1'b1;
            w_cnt_nxt   = r_sample_cnt + 16'd1;
          end else begin
            w_state_nxt = ST_SCK_HI;
            w_sck_nxt   = 1'b1;
          end
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnv_nxt   = 1'b0;
        w_sck_nxt   = 1'b0;
      end
    endcase
  end

  // state, counters and all outputs registered together
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_tmr        <= '0;
      r_bit        <= '0;
      r_cnv        <= 1'b0;
      r_sck        <= 1'b0;
      r_busy       <= 1'b0;
      r_dr         <= 1'b0;
      r_ovr        <= 1'b0;
      r_sample_cnt <= 16'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_tmr        <= w_tmr_nxt;
      r_bit        <= w_bit_nxt;
      r_cnv        <= w_cnv_nxt;
      r_sck        <= w_sck_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_dr         <= w_dr_nxt;
      r_ovr        <= w_ovr_nxt;
      r_sample_cnt <= w_cnt_nxt;
    end
  end

  assign cnv          = r_cnv;
  assign sck          = r_sck;
  assign busy         = r_busy;
  assign data_ready   = r_dr;
  assign overrun      = r_ovr;
  assign sample_count = r_sample_cnt;

endmodule
